// File: rtl/freq_sweep_unit.sv
// Frequency-sweep engine for a square-wave channel: shadow frequency, periodic add/sub sweep, overflow mute.
// Latency: every output is registered; pulses (freq_update, channel_off) appear one clk after the qualifying strobe.
// Backpressure: none; strobes are consumed in the clk they arrive, trigger beats a coincident sweep tick.
module freq_sweep_unit #(
    parameter int FREQ_W   = 11,
    parameter int PERIOD_W = 3,
    parameter int SHIFT_W  = 3,
    localparam int CW      = PERIOD_W + 1 + SHIFT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              slow_clk_en,
    input  logic              cpu_en,
    input  logic              sweep_tick_en,
    input  logic [CW-1:0]     ctrl_wdata,
    input  logic              ctrl_write,
    output logic [CW-1:0]     ctrl,
    input  logic              trigger,
    input  logic [FREQ_W-1:0] freq_in,
    output logic [FREQ_W-1:0] new_freq,
    output logic              freq_update,
    output logic              channel_off,
    output logic              sweep_enabled
);

    localparam int TW = PERIOD_W + 1;

    logic [FREQ_W-1:0]   shadow;
    logic [TW-1:0]       timer;
    logic                negate_used;

    logic                cpu_wr, trig, tick, lockout;
    logic [CW-1:0]       t_ctrl;
    logic [PERIOD_W-1:0] o_period, t_period;
    logic                o_neg, t_neg;
    logic [SHIFT_W-1:0]  o_shift, t_shift;
    logic [FREQ_W:0]     trig_calc, n1, n2;

    // One sweep step at FREQ_W+1 bits; the top bit flags add-mode overflow.
    function automatic logic [FREQ_W:0] calc(input logic [FREQ_W-1:0] x,
                                             input logic neg,
                                             input logic [SHIFT_W-1:0] sh);
        logic [FREQ_W:0] ext;
        logic [FREQ_W:0] delta;
        ext   = {1'b0, x};
        delta = ext >> sh;
        calc  = neg ? (ext - delta) : (ext + delta);
    endfunction

    // A zero period field means the longest interval, 2^PERIOD_W ticks.
    function automatic logic [TW-1:0] reload(input logic [PERIOD_W-1:0] p);
        reload = (p == '0) ? {1'b1, {PERIOD_W{1'b0}}} : {1'b0, p};
    endfunction

    assign cpu_wr  = cpu_en & ctrl_write;
    assign trig    = cpu_en & trigger;
    assign tick    = slow_clk_en & sweep_tick_en & ~trig;

    // Ticks see the register as it was; a trigger sees a same-clk write.
    assign o_period = ctrl[CW-1 -: PERIOD_W];
    assign o_neg    = ctrl[SHIFT_W];
    assign o_shift  = ctrl[SHIFT_W-1:0];
    assign t_ctrl   = cpu_wr ? ctrl_wdata : ctrl;
    assign t_period = t_ctrl[CW-1 -: PERIOD_W];
    assign t_neg    = t_ctrl[SHIFT_W];
    assign t_shift  = t_ctrl[SHIFT_W-1:0];

    // Leaving negate mode after a subtracting sweep has been applied kills the channel.
    assign lockout  = cpu_wr & negate_used & ~ctrl_wdata[SHIFT_W];

    assign trig_calc = calc(freq_in, t_neg, t_shift);
    assign n1        = calc(shadow, o_neg, o_shift);
    assign n2        = calc(n1[FREQ_W-1:0], o_neg, o_shift);

    // Control register, shadow frequency, sweep timer and one-clk event pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl          <= '0;
            shadow        <= '0;
            timer         <= '0;
            sweep_enabled <= 1'b0;
            negate_used   <= 1'b0;
            new_freq      <= '0;
            freq_update   <= 1'b0;
            channel_off   <= 1'b0;
        end else begin
            freq_update <= 1'b0;
            channel_off <= 1'b0;

            if (cpu_wr) begin
                ctrl <= ctrl_wdata;
            end

            if (tick) begin
                if (timer > TW'(1)) begin
                    timer <= timer - TW'(1);
                end else begin
                    timer <= reload(o_period);
                    if (sweep_enabled && (o_period != '0)) begin
                        if (n1[FREQ_W]) begin
                            channel_off   <= 1'b1;
                            sweep_enabled <= 1'b0;
                        end else begin
                            if (o_neg) begin
                                negate_used <= 1'b1;
                            end
                            if (o_shift != '0) begin
                                shadow      <= n1[FREQ_W-1:0];
                                new_freq    <= n1[FREQ_W-1:0];
                                freq_update <= 1'b1;
                                // Look-ahead: the next step would already overflow.
                                if (n2[FREQ_W]) begin
                                    channel_off <= 1'b1;
                                end
                            end
                        end
                    end
                end
            end

            if (lockout) begin
                channel_off   <= 1'b1;
                sweep_enabled <= 1'b0;
            end

            // Trigger is last so it owns the enable and lockout state it restarts.
            if (trig) begin
                shadow        <= freq_in;
                timer         <= reload(t_period);
                negate_used   <= 1'b0;
                sweep_enabled <= (t_period != '0) | (t_shift != '0);
                if ((t_shift != '0) && trig_calc[FREQ_W]) begin
                    channel_off <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_sweep_unit.sv
// Self-checking bench for freq_sweep_unit: directed scenarios plus randomized strobes against a reference model.
// Latency: outputs are sampled 1 time unit after each rising edge and compared with the model's post-edge state.
// Backpressure: none; the bench drives one strobe pattern per clk.
module tb_freq_sweep_unit;

    localparam int FREQ_W   = 11;
    localparam int PERIOD_W = 3;
    localparam int SHIFT_W  = 3;
    localparam int CW       = PERIOD_W + 1 + SHIFT_W;
    localparam int FMAX     = (1 << FREQ_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              slow_clk_en = 1'b0;
    logic              cpu_en = 1'b0;
    logic              sweep_tick_en = 1'b0;
    logic [CW-1:0]     ctrl_wdata = '0;
    logic              ctrl_write = 1'b0;
    logic [CW-1:0]     ctrl;
    logic              trigger = 1'b0;
    logic [FREQ_W-1:0] freq_in = '0;
    logic [FREQ_W-1:0] new_freq;
    logic              freq_update;
    logic              channel_off;
    logic              sweep_enabled;

    int checks = 0;
    int errors = 0;

    // Reference state, kept as plain integers.
    int m_per, m_neg, m_sh, m_shadow, m_cnt, m_on, m_lock, m_nf;
    int e_upd, e_off;

    freq_sweep_unit #(.FREQ_W(FREQ_W), .PERIOD_W(PERIOD_W), .SHIFT_W(SHIFT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .slow_clk_en   (slow_clk_en),
        .cpu_en        (cpu_en),
        .sweep_tick_en (sweep_tick_en),
        .ctrl_wdata    (ctrl_wdata),
        .ctrl_write    (ctrl_write),
        .ctrl          (ctrl),
        .trigger       (trigger),
        .freq_in       (freq_in),
        .new_freq      (new_freq),
        .freq_update   (freq_update),
        .channel_off   (channel_off),
        .sweep_enabled (sweep_enabled)
    );

    always #5 clk = ~clk;

    function automatic int mk(int p, int n, int s);
        return (p << (SHIFT_W + 1)) | (n << SHIFT_W) | s;
    endfunction

    function automatic int sweep_of(int x, int neg, int sh);
        return neg ? (x - (x >> sh)) : (x + (x >> sh));
    endfunction

    function automatic int interval(int p);
        return (p == 0) ? (1 << PERIOD_W) : p;
    endfunction

    function automatic void model_reset();
        m_per = 0; m_neg = 0; m_sh = 0; m_shadow = 0; m_cnt = 0;
        m_on = 0; m_lock = 0; m_nf = 0; e_upd = 0; e_off = 0;
    endfunction

    // Reference behaviour for one clk given the qualified events.
    function automatic void model(int wr, int wd, int trg, int fin, int tck);
        int v;
        bit lock_hit;
        e_upd = 0;
        e_off = 0;
        lock_hit = (wr != 0) && (m_lock != 0) && (((wd >> SHIFT_W) & 1) == 0);
        if (tck != 0 && trg == 0) begin
            if (m_cnt > 1) begin
                m_cnt = m_cnt - 1;
            end else begin
                m_cnt = interval(m_per);
                if (m_on != 0 && m_per != 0) begin
                    v = sweep_of(m_shadow, m_neg, m_sh);
                    if (v > FMAX) begin
                        e_off = 1;
                        m_on  = 0;
                    end else begin
                        if (m_neg != 0) m_lock = 1;
                        if (m_sh != 0) begin
                            m_shadow = v;
                            m_nf     = v;
                            e_upd    = 1;
                            if (sweep_of(v, m_neg, m_sh) > FMAX) e_off = 1;
                        end
                    end
                end
            end
        end
        if (wr != 0) begin
            m_per = wd >> (SHIFT_W + 1);
            m_neg = (wd >> SHIFT_W) & 1;
            m_sh  = wd & ((1 << SHIFT_W) - 1);
        end
        if (lock_hit) begin
            e_off = 1;
            m_on  = 0;
        end
        if (trg != 0) begin
            m_shadow = fin;
            m_cnt    = interval(m_per);
            m_lock   = 0;
            m_on     = (m_per != 0 || m_sh != 0) ? 1 : 0;
            if (m_sh != 0 && sweep_of(fin, m_neg, m_sh) > FMAX) e_off = 1;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one clk of raw pins, then compare every output with the model.
    task automatic step(input logic ce, input logic cw, input int wd, input logic trg,
                        input int fin, input logic sce, input logic ste);
        cpu_en        = ce;
        ctrl_write    = cw;
        ctrl_wdata    = CW'(wd);
        trigger       = trg;
        freq_in       = FREQ_W'(fin);
        slow_clk_en   = sce;
        sweep_tick_en = ste;
        @(posedge clk);
        #1;
        model(int'(ce & cw), wd, int'(ce & trg), fin, int'(sce & ste));
        chk("ctrl", 32'(ctrl), 32'(mk(m_per, m_neg, m_sh)));
        chk("new_freq", 32'(new_freq), 32'(m_nf));
        chk("freq_update", 32'(freq_update), 32'(e_upd));
        chk("channel_off", 32'(channel_off), 32'(e_off));
        chk("sweep_enabled", 32'(sweep_enabled), 32'(m_on));
        cpu_en = 1'b0; ctrl_write = 1'b0; trigger = 1'b0;
        slow_clk_en = 1'b0; sweep_tick_en = 1'b0;
    endtask

    task automatic wr(input int w);
        step(1'b1, 1'b1, w, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic trig(input int f);
        step(1'b1, 1'b0, 0, 1'b1, f, 1'b0, 1'b0);
    endtask

    task automatic tick();
        step(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, 32'(ctrl), 32'd0);
        chk({tag, "_new_freq"}, 32'(new_freq), 32'd0);
        chk({tag, "_freq_update"}, 32'(freq_update), 32'd0);
        chk({tag, "_channel_off"}, 32'(channel_off), 32'd0);
        chk({tag, "_sweep_enabled"}, 32'(sweep_enabled), 32'd0);
    endtask

    initial begin
        int ev;
        int f;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;

        // Overflow detected at trigger: mute, no write-back.
        wr(mk(1, 0, 1));
        trig('h700);
        chk("trig_ovf_off", 32'(channel_off), 32'd1);
        chk("trig_ovf_upd", 32'(freq_update), 32'd0);

        // Add sweep, period 2, shift 2.
        wr(mk(2, 0, 2));
        trig('h100);
        chk("add_en", 32'(sweep_enabled), 32'd1);
        tick();
        chk("add_t1_upd", 32'(freq_update), 32'd0);
        tick();
        chk("add_t2_upd", 32'(freq_update), 32'd1);
        chk("add_t2_nf", 32'(new_freq), 32'h140);
        tick();
        tick();
        chk("add_t4_upd", 32'(freq_update), 32'd1);
        chk("add_t4_nf", 32'(new_freq), 32'h190);

        // Second overflow check mutes in the same clk as the write-back.
        wr(mk(1, 0, 1));
        trig('h500);
        tick();
        chk("second_nf", 32'(new_freq), 32'h780);
        chk("second_upd", 32'(freq_update), 32'd1);
        chk("second_off", 32'(channel_off), 32'd1);

        // Negate lockout.
        wr(mk(1, 1, 1));
        trig('h400);
        tick();
        chk("neg_nf", 32'(new_freq), 32'h200);
        wr(mk(1, 0, 1));
        chk("lock_off", 32'(channel_off), 32'd1);
        chk("lock_en", 32'(sweep_enabled), 32'd0);
        tick();
        chk("lock_suppress", 32'(freq_update), 32'd0);
        wr(mk(1, 1, 1));
        trig('h400);
        wr(mk(1, 0, 1));
        chk("nolock_off", 32'(channel_off), 32'd0);
        chk("nolock_en", 32'(sweep_enabled), 32'd1);

        // Period 0: enabled but never sweeps.
        wr(mk(0, 0, 3));
        trig('h100);
        chk("p0_en", 32'(sweep_enabled), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("p0_upd", 32'(freq_update), 32'd0);
        end

        // Trigger and tick together: tick dropped, timer reloaded.
        wr(mk(2, 0, 2));
        trig('h100);
        tick();
        step(1'b1, 1'b0, 0, 1'b1, 'h100, 1'b1, 1'b1);
        chk("coll_tt_upd", 32'(freq_update), 32'd0);
        tick();
        chk("coll_tt_upd2", 32'(freq_update), 32'd0);
        tick();
        chk("coll_tt_nf", 32'(new_freq), 32'h140);

        // Write and tick together: tick uses the old shift.
        wr(mk(1, 0, 1));
        trig('h100);
        step(1'b1, 1'b1, mk(1, 0, 2), 1'b0, 0, 1'b1, 1'b1);
        chk("coll_wt_nf", 32'(new_freq), 32'h180);
        chk("coll_wt_ctrl", 32'(ctrl), 32'(mk(1, 0, 2)));

        // Write and trigger together: trigger uses the new ctrl.
        wr(mk(0, 0, 0));
        step(1'b1, 1'b1, mk(1, 0, 2), 1'b1, 'h100, 1'b0, 1'b0);
        chk("coll_wtr_en", 32'(sweep_enabled), 32'd1);
        tick();
        chk("coll_wtr_nf", 32'(new_freq), 32'h140);

        // Reset asserted mid-sweep (timer at 2) clears everything at once.
        wr(mk(2, 0, 2));
        trig('h100);
        reset_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_reset_upd", 32'(freq_update), 32'd0);
            chk("post_reset_off", 32'(channel_off), 32'd0);
        end

        // Randomized traffic, one event class per clk.
        for (int i = 0; i < 3000; i++) begin
            ev = $urandom_range(0, 19);
            f  = int'($urandom_range(0, FMAX)) >> $urandom_range(0, 3);
            if (ev < 3) begin
                wr(int'($urandom_range(0, (1 << CW) - 1)));
            end else if (ev < 5) begin
                trig(f);
            end else if (ev < 15) begin
                tick();
            end else if (ev == 15) begin
                step(1'b0, 1'b1, int'($urandom_range(0, (1 << CW) - 1)), 1'b1, f, 1'b0, 1'b1);
            end else if (ev == 16) begin
                step(1'b0, 1'b0, 0, 1'b0, f, 1'b1, 1'b0);
            end else begin
                step(1'b0, 1'b0, 0, 1'b0, f, 1'b0, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
